instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Hardware replacement for the bench-side instruction feeder of cpu.
//  Holds a program in an internal instruction RAM and issues one 16-bit word per clock on current_instruction.
//  Stops at the halt word and stalls after TENSOR_CORE_OPERATE until the tensor core reports done.
//  Sits between the host/loader and cpu.current_instruction.
// PARAMETERS
//  ADDR_WIDTH   10        instruction RAM depth = 2**ADDR_WIDTH words
//  INSTR_WIDTH  16        instruction word width
//  HALT_WORD    16'hFFFF  end-of-program marker; never issued
// PORTS
//  clock_in                  in   1           single clock, all state on posedge
//  reset_n_in                in   1           asynchronous, active-low reset
//  load_enable_in            in   1           write load_data_in to RAM[load_address_in]
//  load_address_in           in   ADDR_WIDTH  program load address
//  load_data_in              in   INSTR_WIDTH program load word
//  start_in                  in   1           begin execution at address 0
//  tensor_core_done_in       in   1           cpu.is_tensor_core_done_with_calculation
//  current_instruction       out  INSTR_WIDTH word presented to cpu; NOP (16'h0000) when not issuing
//  instruction_valid_out     out  1           current_instruction is a real program word this cycle
//  program_counter_out       out  ADDR_WIDTH  address of the word on current_instruction
//  busy_out                  out  1           state is FETCH, RUN or WAIT_TENSOR
//  halted_out                out  1           state is HALTED
// BEHAVIOUR
//  Reset: state IDLE. current_instruction=0, instruction_valid_out=0, program_counter_out=0, busy_out=0, halted_out=0.
//    RAM contents are not cleared.
//  Reset asserted mid-run: immediate return to IDLE and NOP output; the program is kept.
//  States:
//    IDLE -> FETCH on start_in.
//    FETCH: synchronous RAM read of address 0; 1 cycle; -> RUN.
//    RUN: issue the read word and prefetch the next address in the same cycle; one word per cycle.
//    WAIT_TENSOR: output NOP; hold the prefetched word.
//    HALTED: -> FETCH on start_in (restart at address 0).
//  Latency: start_in at posedge N gives the first word valid after posedge N+2.
//  Halt: a fetched word equal to HALT_WORD is not issued.
//    Outputs go to NOP, instruction_valid_out=0, state -> HALTED.
//    program_counter_out holds the halt word's address.
//  Stall: when an issued word has [15:12]==4'b1001 (TENSOR_CORE_OPERATE), enter WAIT_TENSOR the next cycle.
//    tensor_core_done_in is ignored in the first WAIT_TENSOR cycle, so a stale done from a prior op is not seen.
//    From the second cycle on, done=1 -> RUN and the held word issues on the following cycle.
//  Wrap-around: the last address (2**ADDR_WIDTH-1) is issued if it is not HALT_WORD; the sequencer then -> HALTED.
//    The PC never wraps to 0.
//  Load port: writes are accepted only in IDLE or HALTED and are ignored while busy_out=1.
//    A load and a start_in in the same cycle: the write completes and start_in takes effect.
//    The first fetch sees the new word.
//  start_in while busy_out=1 is ignored.
// CONFIGURATION
//  SEQUENCER_SINGLE_STEP_EN defined:
//    Adds ports step_mode_in (in, 1) and step_in (in, 1).
//    With step_mode_in=1, RUN issues exactly one word per step_in cycle and outputs NOP between steps.
//    The halt and stall rules are unchanged.
//    With step_mode_in=0, behaviour is identical to the undefined build.
//  Undefined: no extra ports; free-running issue only.
// TESTING
//  1. Load {16'h6105,16'h6203,16'h2312,16'hFFFF} at 0..3, pulse start.
//     Expect 6105, 6203, 2312 on three consecutive cycles with valid=1 and PC 0,1,2.
//     Then halted_out=1, PC=3, NOP output.
//  2. Program {16'h9000,16'h0000,16'hFFFF}, tensor_core_done_in held 1.
//     Expect exactly one NOP/wait cycle after 9000 before 0000 issues.
//     With done low for 5 cycles, 0000 issues 1 cycle after done rises.
//  3. Mid-run load of 16'h1234 to address 1.
//     Expect RAM unchanged; after halt, the reload is accepted and restart issues 1234 at PC 1.
//  4. Pull reset_n_in low between clock edges mid-run.
//     Expect all outputs at reset values before the next edge.
//     Then start_in re-runs the same program from PC 0.
//  5. Fill all 1024 words with 16'h0000 and start.
//     Expect 1024 valid issues, PC 0..1023, then halted_out=1 with no wrap to 0.
//  6. SEQUENCER_SINGLE_STEP_EN, step_mode_in=1, program of test 1, step_in pulsed every 4 cycles.
//     Expect one valid word per pulse; halted after the 4th pulse.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: holds a program in an on-chip RAM and feeds one word per clock to the cpu.
// Optional single-step issue is compiled in with `define SEQUENCER_SINGLE_STEP_EN.
module instruction_sequencer #(
  parameter int                     ADDR_WIDTH  = 10,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 16'hFFFF
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   load_enable_in,
  input  logic [ADDR_WIDTH-1:0]  load_address_in,
  input  logic [INSTR_WIDTH-1:0] load_data_in,
  input  logic                   start_in,
  input  logic                   tensor_core_done_in,
`ifdef SEQUENCER_SINGLE_STEP_EN
  input  logic                   step_mode_in,
  input  logic                   step_in,
`endif
  output logic [INSTR_WIDTH-1:0] current_instruction,
  output logic                   instruction_valid_out,
  output logic [ADDR_WIDTH-1:0]  program_counter_out,
  output logic                   busy_out,
  output logic                   halted_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_RUN         = 3'd2,
    S_WAIT_TENSOR = 3'd3,
    S_HALTED      = 3'd4
  } state_t;

  function automatic logic is_tensor_op(input logic [INSTR_WIDTH-1:0] word);
    return word[INSTR_WIDTH-1 -: 4] == 4'b1001;
  endfunction

  state_t                 state_r, state_s;
  // Address of the word held in rdata_r; the extra MSB marks "past the last address".
  logic [ADDR_WIDTH:0]    addr_r, addr_s;
  logic                   wait_first_r, wait_first_s;
  logic [INSTR_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [INSTR_WIDTH-1:0] rdata_r;
  logic                   rd_en_s;
  logic [ADDR_WIDTH-1:0]  rd_addr_s;
  logic                   wr_en_s;
  logic                   advance_s;
  logic                   issue_s;
  logic [INSTR_WIDTH-1:0] instr_s;
  logic                   valid_s;
  logic [ADDR_WIDTH-1:0]  pc_s;

`ifdef SEQUENCER_SINGLE_STEP_EN
  assign advance_s = ~step_mode_in | step_in;
`else
  assign advance_s = 1'b1;
`endif

  assign wr_en_s = load_enable_in && ((state_r == S_IDLE) || (state_r == S_HALTED));

  // Next-state, RAM read request and next output values.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    wait_first_s = 1'b0;
    rd_en_s      = 1'b0;
    rd_addr_s    = addr_r[ADDR_WIDTH-1:0];
    issue_s      = 1'b0;
    instr_s      = {INSTR_WIDTH{1'b0}};
    valid_s      = 1'b0;
    pc_s         = program_counter_out;
    case (state_r)
      S_IDLE, S_HALTED: begin
        if (start_in) state_s = S_FETCH;
        else          state_s = state_r;
      end
      S_FETCH: begin
        rd_en_s   = 1'b1;
        rd_addr_s = {ADDR_WIDTH{1'b0}};
        addr_s    = {(ADDR_WIDTH+1){1'b0}};
        state_s   = S_RUN;
      end
      S_RUN: begin
        if (advance_s) issue_s = 1'b1;
        else           issue_s = 1'b0;
      end
      S_WAIT_TENSOR: begin
        // The first wait cycle never looks at done, so a stale done is not taken.
        if (!wait_first_r && tensor_core_done_in) begin
          if (advance_s) issue_s = 1'b1;
          else           state_s = S_RUN;
        end else begin
          state_s = S_WAIT_TENSOR;
        end
      end
      default: state_s = S_IDLE;
    endcase

    if (issue_s) begin
      if (addr_r[ADDR_WIDTH]) begin
        state_s = S_HALTED;
      end else if (rdata_r == HALT_WORD) begin
        state_s = S_HALTED;
        pc_s    = addr_r[ADDR_WIDTH-1:0];
      end else begin
        instr_s   = rdata_r;
        valid_s   = 1'b1;
        pc_s      = addr_r[ADDR_WIDTH-1:0];
        rd_en_s   = 1'b1;
        rd_addr_s = addr_r[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        addr_s    = addr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (is_tensor_op(rdata_r)) begin
          state_s      = S_WAIT_TENSOR;
          wait_first_s = 1'b1;
        end else begin
          state_s = S_RUN;
        end
      end
    end else begin
      valid_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r               <= S_IDLE;
      addr_r                <= {(ADDR_WIDTH+1){1'b0}};
      wait_first_r          <= 1'b0;
      current_instruction   <= {INSTR_WIDTH{1'b0}};
      instruction_valid_out <= 1'b0;
      program_counter_out   <= {ADDR_WIDTH{1'b0}};
      busy_out              <= 1'b0;
      halted_out            <= 1'b0;
    end else begin
      state_r               <= state_s;
      addr_r                <= addr_s;
      wait_first_r          <= wait_first_s;
      current_instruction   <= instr_s;
      instruction_valid_out <= valid_s;
      program_counter_out   <= pc_s;
      busy_out              <= (state_s == S_FETCH) || (state_s == S_RUN) || (state_s == S_WAIT_TENSOR);
      halted_out            <= (state_s == S_HALTED);
    end
  end

  // Program RAM: contents survive reset, read port is registered.
  always_ff @(posedge clock_in) begin
    if (wr_en_s) mem_r[load_address_in] <= load_data_in;
    if (rd_en_s) rdata_r <= mem_r[rd_addr_s];
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed vector table, corner sequences,
// and randomized programs checked against a program-walking reference model.
module tb_instruction_sequencer;

  logic        clock_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        load_enable_in = 1'b0;
  logic [9:0]  load_address_in = 10'd0;
  logic [15:0] load_data_in = 16'h0000;
  logic        start_in = 1'b0;
  logic        tensor_core_done_in = 1'b0;
  logic        step_mode_v = 1'b0;
  logic        step_v = 1'b0;
  logic [15:0] current_instruction;
  logic        instruction_valid_out;
  logic [9:0]  program_counter_out;
  logic        busy_out;
  logic        halted_out;

  int pass_count = 0;
  int total_count = 0;

  instruction_sequencer dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .load_enable_in(load_enable_in), .load_address_in(load_address_in), .load_data_in(load_data_in),
    .start_in(start_in), .tensor_core_done_in(tensor_core_done_in),
`ifdef SEQUENCER_SINGLE_STEP_EN
    .step_mode_in(step_mode_v), .step_in(step_v),
`endif
    .current_instruction(current_instruction), .instruction_valid_out(instruction_valid_out),
    .program_counter_out(program_counter_out), .busy_out(busy_out), .halted_out(halted_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: walks the program by address, knows nothing of the RTL's registers.
  localparam int P_IDLE = 0, P_FETCH = 1, P_RUN = 2, P_WAIT = 3;
  logic [15:0] m_mem [0:1023];
  int          m_phase = P_IDLE;
  int          m_next = 0;
  int          m_k = 0;
  logic        m_halted = 1'b0;
  logic [9:0]  m_pc = 10'd0;
  logic [15:0] e_instr;
  logic        e_valid;

  task automatic m_attempt();
    if (m_next == 1024) begin
      m_phase = P_IDLE; m_halted = 1'b1; m_pc = 10'd1023;
    end else if (m_mem[m_next] == 16'hFFFF) begin
      m_phase = P_IDLE; m_halted = 1'b1; m_pc = 10'(m_next);
    end else begin
      e_instr = m_mem[m_next]; e_valid = 1'b1; m_pc = 10'(m_next);
      m_phase = (m_mem[m_next][15:12] == 4'h9) ? P_WAIT : P_RUN;
      m_k = 0;
      m_next++;
    end
  endtask

  task automatic m_edge();
    logic adv;
    adv = !step_mode_v || step_v;
    e_instr = 16'h0000; e_valid = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (load_enable_in) m_mem[load_address_in] = load_data_in;
        if (start_in) begin m_phase = P_FETCH; m_halted = 1'b0; m_next = 0; end
      end
      P_FETCH: m_phase = P_RUN;
      P_RUN:   if (adv) m_attempt();
      P_WAIT: begin
        m_k++;
        if (m_k >= 2 && tensor_core_done_in) begin
          if (adv) m_attempt();
          else m_phase = P_RUN;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic drive(input logic st, input logic dn, input logic ld, input logic [9:0] la,
                       input logic [15:0] lw, input logic sm, input logic sp);
    @(negedge clock_in);
    start_in = st; tensor_core_done_in = dn; load_enable_in = ld;
    load_address_in = la; load_data_in = lw; step_mode_v = sm; step_v = sp;
    @(posedge clock_in);
  endtask

  // One clock with model prediction and comparison half way to the next edge.
  task automatic cycle(input logic st, input logic dn, input logic ld, input logic [9:0] la,
                       input logic [15:0] lw, input logic sm, input logic sp);
    drive(st, dn, ld, la, lw, sm, sp);
    m_edge();
    #1;
    check("instr", current_instruction, e_instr);
    check("valid", instruction_valid_out, e_valid);
    check("busy", busy_out, m_phase != P_IDLE);
    check("halted", halted_out, m_halted);
    if (e_valid || m_halted) check("pc", program_counter_out, m_pc);
  endtask

  task automatic reset_now(input string tag);
    reset_n_in = 1'b0;
    #1;
    check({tag, " instr"}, current_instruction, 16'h0000);
    check({tag, " valid"}, instruction_valid_out, 1'b0);
    check({tag, " pc"}, program_counter_out, 10'd0);
    check({tag, " busy"}, busy_out, 1'b0);
    check({tag, " halted"}, halted_out, 1'b0);
    @(negedge clock_in);
    start_in = 1'b0; load_enable_in = 1'b0; tensor_core_done_in = 1'b0; step_v = 1'b0;
    reset_n_in = 1'b1;
    m_phase = P_IDLE; m_halted = 1'b0; m_pc = 10'd0;
  endtask

  logic [15:0] got_pc1;

  // Runs until the model is idle; noise adds random done/start/load traffic.
  task automatic run_to_idle(input int max, input logic noise, input logic sm, input int period,
                             output int nvalid);
    logic dn, st, ld, sp;
    nvalid = 0;
    for (int i = 0; i < max && m_phase != P_IDLE; i++) begin
      dn = noise ? 1'($urandom_range(0, 1)) : 1'b1;
      st = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      ld = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      sp = (period == 0) ? 1'($urandom_range(0, 1)) : ((i % period) == (period - 1));
      cycle(st, dn, ld, 10'($urandom_range(0, 1023)), 16'($urandom), sm, sp);
      if (instruction_valid_out) nvalid++;
      if (instruction_valid_out && program_counter_out == 10'd1) got_pc1 = current_instruction;
    end
    check("run bound busy", busy_out, 1'b0);
  endtask

  typedef struct {
    logic st; logic dn; logic ld; logic [9:0] la; logic [15:0] lw;
    logic [15:0] instr; logic valid; logic [9:0] pc; logic chk_pc; logic busy; logic halted;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic st, input logic dn, input logic ld, input logic [9:0] la,
                              input logic [15:0] lw, input logic [15:0] instr, input logic valid,
                              input logic [9:0] pc, input logic chk_pc, input logic busy,
                              input logic halted);
    vec_t v;
    v.st = st; v.dn = dn; v.ld = ld; v.la = la; v.lw = lw; v.instr = instr; v.valid = valid;
    v.pc = pc; v.chk_pc = chk_pc; v.busy = busy; v.halted = halted;
    return v;
  endfunction

  logic [15:0] prog1 [4];
  int          nv;
  int          len;
  logic        sm_r;
  logic [15:0] w;

  initial begin
    prog1[0] = 16'h6105; prog1[1] = 16'h6203; prog1[2] = 16'h2312; prog1[3] = 16'hFFFF;
    for (int i = 0; i < 1024; i++) m_mem[i] = 16'hFFFF;

    // Test 1 and 2 as a vector table (program 1 is loaded before it runs).
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h6105, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h6203, 1, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h2312, 1, 2, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 3, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 3, 1, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 16'h9000, 16'h0000, 0, 3, 1, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 0, 3, 1, 0, 1));
    vt.push_back(mk(0, 0, 1, 2, 16'hFFFF, 16'h0000, 0, 3, 1, 0, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h9000, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0, 2, 1, 0, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h9000, 1, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++) vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 2, 1, 0, 1));

    #12;
    reset_now("reset");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 10'(i), prog1[i], 0, 0);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].st, vt[i].dn, vt[i].ld, vt[i].la, vt[i].lw, 0, 0);
      if (vt[i].ld) m_mem[vt[i].la] = vt[i].lw;
      #1;
      check($sformatf("row%0d instr", i), current_instruction, vt[i].instr);
      check($sformatf("row%0d valid", i), instruction_valid_out, vt[i].valid);
      check($sformatf("row%0d busy", i), busy_out, vt[i].busy);
      check($sformatf("row%0d halted", i), halted_out, vt[i].halted);
      if (vt[i].chk_pc) check($sformatf("row%0d pc", i), program_counter_out, vt[i].pc);
    end
    #2;
    reset_now("resync reset");

    // Test 3: loads while running are dropped; after halt they land.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 10'(i), prog1[i], 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 10'd1, 16'h1234, 0, 0);
    run_to_idle(20, 0, 0, 1, nv);
    cycle(0, 0, 1, 10'd1, 16'h1234, 0, 0);
    got_pc1 = 16'h0000;
    cycle(1, 0, 0, 0, 0, 0, 0);
    run_to_idle(20, 0, 0, 1, nv);
    check("reload word at pc1", got_pc1, 16'h1234);

    // Test 4: asynchronous reset mid-run, then restart of the retained program.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_now("midrun reset");
    cycle(1, 0, 0, 0, 0, 0, 0);
    run_to_idle(20, 0, 0, 1, nv);
    check("rerun issue count", nv, 3);

    // Randomized programs; word 0 is loaded in the same cycle as start.
    for (int it = 0; it < 15; it++) begin
      len = $urandom_range(2, 30);
      sm_r = 1'b0;
`ifdef SEQUENCER_SINGLE_STEP_EN
      sm_r = 1'($urandom_range(0, 1));
`endif
      for (int j = 1; j < len; j++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'h9;
        if (w == 16'hFFFF || j == len - 1) w = (j == len - 1) ? 16'hFFFF : 16'h0001;
        cycle(0, 0, 1, 10'(j), w, 0, 0);
      end
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0002;
      cycle(1, 0, 1, 10'd0, w, sm_r, 0);
      run_to_idle(400, 1, sm_r, 0, nv);
    end

    // Test 5: full-depth program of NOPs, no wrap back to address 0.
    for (int i = 0; i < 1024; i++) cycle(0, 0, 1, 10'(i), 16'h0000, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    run_to_idle(1100, 0, 0, 1, nv);
    check("full depth issue count", nv, 1024);
    check("full depth final pc", program_counter_out, 10'd1023);
    check("full depth halted", halted_out, 1'b1);

`ifdef SEQUENCER_SINGLE_STEP_EN
    // Test 6: single step, one pulse every 4 cycles.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 10'(i), prog1[i], 1, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    run_to_idle(60, 0, 1, 4, nv);
    check("step issue count", nv, 3);
    check("step halted", halted_out, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
